// File: rtl/cpu_mul_pkg.sv
// Shared types for the RV64M multiply unit: operation encodings (funct3[1:0])
// and control states.
package cpu_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } mul_state_t;

  // rs1 is treated as signed for everything except MULHU.
  function automatic logic aIsSigned(mul_op_t op);
    return op != MULHU;
  endfunction

  function automatic logic bIsSigned(mul_op_t op);
    return (op == MUL) || (op == MULH);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BPC shift-add step: adds multiplicand * BPC multiplier bits into
// the top of the accumulator, then shifts the accumulator right by BPC.
module mul_step #(
  parameter int DATA_W = 64,
  parameter int BPC    = 4
) (
  input  logic [DATA_W-1:0]   mcand_i,
  input  logic [BPC-1:0]      bits_i,
  input  logic [2*DATA_W-1:0] acc_i,
  output logic [2*DATA_W-1:0] acc_o
);

  logic [DATA_W+BPC-1:0]   partial;
  logic [2*DATA_W+BPC-1:0] sum;

  // After DATA_W/BPC steps each partial product has drifted down to its weight.
  always_comb begin
    partial = {{BPC{1'b0}}, mcand_i} * {{DATA_W{1'b0}}, bits_i};
    sum     = {{BPC{1'b0}}, acc_i} + {partial, {DATA_W{1'b0}}};
    acc_o   = sum[2*DATA_W+BPC-1:BPC];
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready handshake,
// tag pass-through, flush abort and global run enable.
module mul_unit
  import cpu_mul_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BPC    = 4,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int ITER  = DATA_W / BPC;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  mul_state_t          state_q, state_d;
  mul_op_t             op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [2*DATA_W-1:0] stepAcc;
  logic [2*DATA_W-1:0] prodFix;
  logic                acceptFire;
  logic                aNeg, bNeg;
  mul_op_t             opIn;

  mul_step #(.DATA_W(DATA_W), .BPC(BPC)) u_step (
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BPC-1:0]),
    .acc_i   (acc_q),
    .acc_o   (stepAcc)
  );

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == BUSY) || (state_q == FIX);
  assign out_result = result_q;
  assign out_tag    = tag_q;

  assign acceptFire = enable && in_valid && in_ready && !flush;
  assign opIn       = mul_op_t'(in_op);
  assign aNeg       = aIsSigned(opIn) && in_a[DATA_W-1];
  assign bNeg       = bIsSigned(opIn) && in_b[DATA_W-1];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    prodFix  = neg_q ? -acc_q : acc_q;

    case (state_q)
      BUSY: begin
        acc_d    = stepAcc;
        mplier_d = mplier_q >> BPC;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        result_d = (op_q == MUL) ? prodFix[DATA_W-1:0] : prodFix[2*DATA_W-1:DATA_W];
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase

    // An accept in DONE overlaps the output handshake and restarts directly.
    if (acceptFire) begin
      op_d     = opIn;
      tag_d    = in_tag;
      neg_d    = aNeg ^ bNeg;
      mcand_d  = aNeg ? -in_a : in_a;
      mplier_d = bNeg ? -in_b : in_b;
      acc_d    = '0;
      cnt_d    = CNT_W'(ITER - 1);
      state_d  = BUSY;
    end

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (enable) begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: scoreboard of expected results pushed at
// accept time and popped when out_valid rises.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  mul_unit #(.DATA_W(64), .BPC(4), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference product using wide signed arithmetic, independent of shift-add.
  function automatic logic [63:0] modelMul(logic [1:0] op, logic [63:0] a, logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    ea = (op != 2'b11) ? {{66{a[63]}}, a} : {66'b0, a};
    eb = (op == 2'b00 || op == 2'b01) ? {{66{b[63]}}, b} : {66'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid for one edge and records the expected outcome.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] tag,
                               input logic [63:0] expRes, input bit record);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    if (record) sbQ.push_back('{res: expRes, tag: tag});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitForValid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_result !== 64'd0) begin errors++; $display("[TB] FAIL reset_result got=%h exp=0", out_result); end
    checks++; if (out_tag !== 5'd0) begin errors++; $display("[TB] FAIL reset_tag got=%h exp=0", out_tag); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul_basic();
    int   n;
    exp_t e;
    applyStimulus(2'b00, 64'd7, 64'd6, 5'd3, 64'd42, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got=%b exp=1", busy); end
    waitForValid(n);
    checks++; if (n != 17) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=17", n); end
    e = sbQ.pop_front();
    checks++; if (out_result !== e.res) begin errors++; $display("[TB] FAIL basic_result got=%h exp=%h", out_result, e.res); end
    checks++; if (out_tag !== e.tag) begin errors++; $display("[TB] FAIL basic_tag got=%h exp=%h", out_tag, e.tag); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_signed_ops();
    logic [1:0]  ops[4]  = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [63:0] as[4]   = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bs[4]   = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] exps[4] = '{64'h4000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    int          n;
    exp_t        e;
    logic [1:0]  op;
    logic [63:0] a, b;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        op = ops[i]; a = as[i]; b = bs[i];
        applyStimulus(op, a, b, 5'(i + 8), exps[i], 1'b1);
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        if (i == 9) b = 64'h8000_0000_0000_0000;
        applyStimulus(op, a, b, 5'(i + 8), modelMul(op, a, b), 1'b1);
      end
      waitForValid(n);
      e = sbQ.pop_front();
      checks++; if (n != 17) begin errors++; $display("[TB] FAIL signed_latency[%0d] got=%0d exp=17", i, n); end
      checks++; if (out_result !== e.res || out_tag !== e.tag) begin errors++; $display("[TB] FAIL signed_result[%0d] op=%0d got=%h/%h exp=%h/%h", i, op, out_result, out_tag, e.res, e.tag); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    exp_t        e;
    logic [63:0] held;
    applyStimulus(2'b11, 64'd1000, 64'd2000, 5'd21, 64'd0, 1'b1);
    out_ready = 1'b0;
    waitForValid(n);
    e = sbQ.pop_front();
    checks++; if (out_result !== e.res || out_tag !== e.tag) begin errors++; $display("[TB] FAIL b2b_first got=%h/%h exp=%h/%h", out_result, out_tag, e.res, e.tag); end
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held || out_tag !== 5'd21) begin
        errors++; $display("[TB] FAIL b2b_hold[%0d] got valid=%b ready=%b res=%h tag=%h exp 1/0/%h/15", i, out_valid, in_ready, out_result, out_tag, held);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_follows got=%b exp=1", in_ready); end
    applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd22, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overlap got valid=%b busy=%b exp 0/1", out_valid, busy); end
    waitForValid(n);
    checks++; if (n != 17) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=17", n); end
    e = sbQ.pop_front();
    checks++; if (out_result !== e.res || out_tag !== e.tag) begin errors++; $display("[TB] FAIL b2b_second got=%h/%h exp=%h/%h", out_result, out_tag, e.res, e.tag); end
    tick();
  endtask

  task automatic test_flush();
    bit sawValid = 1'b0;
    applyStimulus(2'b00, 64'd9, 64'd9, 5'd4, 64'd0, 1'b0);
    repeat (7) tick();
    flush = 1'b1;
    applyStimulus(2'b00, 64'd3, 64'd3, 5'd5, 64'd0, 1'b0);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_idle got busy=%b ready=%b valid=%b exp 0/1/0", busy, in_ready, out_valid);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid === 1'b1 || busy === 1'b1) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_result got activity=%b exp=0", sawValid); end
  endtask

  task automatic test_enable_stall();
    int   n;
    exp_t e;
    applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    repeat (5) tick();
    enable = 1'b0;
    flush  = 1'b1;
    repeat (10) tick();
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_frozen got busy=%b valid=%b exp 1/0", busy, out_valid); end
    flush  = 1'b0;
    enable = 1'b1;
    waitForValid(n);
    if (n >= 0) n += 15;
    checks++; if (n != 27) begin errors++; $display("[TB] FAIL stall_latency got=%0d exp=27", n); end
    e = sbQ.pop_front();
    checks++; if (out_result !== e.res || out_tag !== e.tag) begin errors++; $display("[TB] FAIL stall_result got=%h/%h exp=%h/%h", out_result, out_tag, e.res, e.tag); end
    tick();
  endtask

  task automatic test_reset_in_fix();
    int   n;
    exp_t e;
    applyStimulus(2'b00, 64'd11, 64'd13, 5'd17, 64'd0, 1'b0);
    repeat (16) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'd0 || out_tag !== 5'd0) begin
      errors++; $display("[TB] FAIL fix_reset got valid=%b busy=%b ready=%b res=%h tag=%h exp 0/0/1/0/0", out_valid, busy, in_ready, out_result, out_tag);
    end
    applyStimulus(2'b11, 64'd3, 64'd5, 5'd7, 64'd0, 1'b1);
    waitForValid(n);
    checks++; if (n != 17) begin errors++; $display("[TB] FAIL post_reset_latency got=%0d exp=17", n); end
    e = sbQ.pop_front();
    checks++; if (out_result !== e.res || out_tag !== e.tag) begin errors++; $display("[TB] FAIL post_reset_result got=%h/%h exp=%h/%h", out_result, out_tag, e.res, e.tag); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_mul_basic();
    test_signed_ops();
    test_back_to_back();
    test_flush();
    test_enable_stall();
    test_reset_in_fix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
